// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the accumulator CPU sequencer:
// opcodes, ALU encodings, controller states, width defaults.
package cpu_pkg;

  localparam int ADRS_W_DEF = 5;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JC    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and flags in,
// load/select strobes and status out.
interface cpu_seq_ctrl_if
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
);

  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            carry;
  logic            pc_ld;
  logic            branch;
  logic            ir_ld;
  logic            adrs_sel;
  logic            acc_ld;
  logic            flags_ld;
  logic [1:0]      alu_op;
  logic            mem_we;
  logic            halted;
  logic            busy;

  modport master (
    input  opcode, zero, carry,
    output pc_ld, branch, ir_ld, adrs_sel,
    output acc_ld, flags_ld, alu_op, mem_we,
    output halted, busy
  );

  modport slave (
    output opcode, zero, carry,
    input  pc_ld, branch, ir_ld, adrs_sel,
    input  acc_ld, flags_ld, alu_op, mem_we,
    input  halted, busy
  );

endinterface

// File: rtl/cpu_branch_dec.sv
// Opcode classifier and branch-condition evaluation
// for the sequencer's DECODE cycle.
module cpu_branch_dec
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            carry,
  output logic            branch,
  output logic            is_mem_op,
  output logic            is_store,
  output logic            is_halt
);

  always_comb begin
    branch    = 1'b0;
    is_mem_op = 1'b0;
    is_store  = 1'b0;
    is_halt   = 1'b0;
    unique case (1'b1)
      opcode == OP_W'(OP_LOAD),
      opcode == OP_W'(OP_ADD),
      opcode == OP_W'(OP_SUB):
        is_mem_op = 1'b1;
      opcode == OP_W'(OP_STORE): begin
        is_mem_op = 1'b1;
        is_store  = 1'b1;
      end
      opcode == OP_W'(OP_JMP): branch  = 1'b1;
      opcode == OP_W'(OP_JZ):  branch  = zero;
      opcode == OP_W'(OP_JC):  branch  = carry;
      opcode == OP_W'(OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Instruction-sequencing FSM for the accumulator CPU.
// Optional breakpoint support: define CPU_SEQ_BREAKPOINT_EN.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int OP_W    = OP_W_DEF
`ifdef CPU_SEQ_BREAKPOINT_EN
  ,
  parameter int ADRS_W  = ADRS_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_req,
`ifdef CPU_SEQ_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADRS_W-1:0] bp_adrs,
  input  logic [ADRS_W-1:0] pc_val,
  output logic              bp_hit,
`endif
  cpu_seq_ctrl_if.master    bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          br, is_mem_op, is_store, is_halt;
  logic          end_instr, go, stop, wait_done;
  logic [1:0]    alu_sel;

  cpu_branch_dec #(.OP_W(OP_W)) u_dec (
    .opcode    (bus.opcode),
    .zero      (bus.zero),
    .carry     (bus.carry),
    .branch    (br),
    .is_mem_op (is_mem_op),
    .is_store  (is_store),
    .is_halt   (is_halt)
  );

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic bp_hold, bp_match;

  assign bp_match = bp_en && (pc_val == bp_adrs);
  assign stop     = bp_match;
  // after a breakpoint, run must drop before it restarts us
  assign go       = step_req || (run && !bp_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit  <= 1'b0;
      bp_hold <= 1'b0;
    end else begin
      bp_hit <= end_instr && bp_match;
      if (end_instr && bp_match)
        bp_hold <= 1'b1;
      else if (!run || (state == S_IDLE && step_req))
        bp_hold <= 1'b0;
    end
  end
`else
  assign stop = 1'b0;
  assign go   = run || step_req;
`endif

  assign wait_done = (cnt == LAST);

  always_comb begin
    alu_sel = ALU_PASS;
    if (bus.opcode == OP_W'(OP_ADD)) alu_sel = ALU_ADD;
    if (bus.opcode == OP_W'(OP_SUB)) alu_sel = ALU_SUB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    end_instr    = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.branch   = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.adrs_sel = 1'b0;
    bus.acc_ld   = 1'b0;
    bus.flags_ld = 1'b0;
    bus.alu_op   = ALU_PASS;
    bus.mem_we   = 1'b0;
    bus.halted   = 1'b0;
    bus.busy     = 1'b1;
    unique case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (go) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (wait_done) begin
          bus.ir_ld = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_nxt = S_HALTED;
        end else begin
          bus.pc_ld  = 1'b1;
          bus.branch = br;
          if (is_mem_op) state_nxt = S_EXEC;
          else           end_instr = 1'b1;
        end
      end
      S_EXEC: begin
        bus.adrs_sel = 1'b1;
        if (is_store) begin
          bus.mem_we = 1'b1;
          end_instr  = 1'b1;
        end else if (wait_done) begin
          bus.acc_ld   = 1'b1;
          bus.flags_ld = 1'b1;
          bus.alu_op   = alu_sel;
          end_instr    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HALTED: begin
        bus.busy   = 1'b0;
        bus.halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (end_instr)
      state_nxt = (run && !stop) ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: table-driven steps with
// hand-computed strobe vectors at MEM_LAT=1 and MEM_LAT=3.
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  // {pc_ld,branch,ir_ld,adrs_sel,acc_ld,flags_ld,alu_op,mem_we,halted,busy}
  localparam logic [10:0] E_IDLE   = 11'b00000000000;
  localparam logic [10:0] E_FETCH  = 11'b00000000001;
  localparam logic [10:0] E_FETCHL = 11'b00100000001;
  localparam logic [10:0] E_DEC    = 11'b10000000001;
  localparam logic [10:0] E_DECB   = 11'b11000000001;
  localparam logic [10:0] E_DECH   = 11'b00000000001;
  localparam logic [10:0] E_LOAD   = 11'b00011100001;
  localparam logic [10:0] E_ADD    = 11'b00011101001;
  localparam logic [10:0] E_SUB    = 11'b00011110001;
  localparam logic [10:0] E_EXW    = 11'b00010000001;
  localparam logic [10:0] E_STORE  = 11'b00010000101;
  localparam logic [10:0] E_HALT   = 11'b00000000010;
  localparam bit L = 1'b0;
  localparam bit H = 1'b1;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        stp;
    logic [2:0]  op;
    logic        z;
    logic        c;
    logic [10:0] exp;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, step_req;
  logic rst3, run3, step3;
  int   asserts = 0;
  int   fails = 0;

  cpu_seq_ctrl_if #(.OP_W(OP_W_DEF)) b1 ();
  cpu_seq_ctrl_if #(.OP_W(OP_W_DEF)) b3 ();

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic                  bp_en, bp_hit, bp_hit3;
  logic [ADRS_W_DEF-1:0] bp_adrs, pc_val;
`endif

  cpu_seq_ctrl #(.MEM_LAT(1)) u1 (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step_req (step_req),
`ifdef CPU_SEQ_BREAKPOINT_EN
    .bp_en    (bp_en),
    .bp_adrs  (bp_adrs),
    .pc_val   (pc_val),
    .bp_hit   (bp_hit),
`endif
    .bus      (b1)
  );

  cpu_seq_ctrl #(.MEM_LAT(3)) u3 (
    .clk      (clk),
    .rst      (rst3),
    .run      (run3),
    .step_req (step3),
`ifdef CPU_SEQ_BREAKPOINT_EN
    .bp_en    (1'b0),
    .bp_adrs  ('0),
    .pc_val   ('0),
    .bp_hit   (bp_hit3),
`endif
    .bus      (b3)
  );

  function automatic step_t mk(bit r, bit rn, bit s,
                               logic [2:0] op, bit z, bit c,
                               logic [10:0] e);
    return '{r, rn, s, op, z, c, e};
  endfunction

  function automatic logic [10:0] obs1();
    return {b1.pc_ld, b1.branch, b1.ir_ld, b1.adrs_sel,
            b1.acc_ld, b1.flags_ld, b1.alu_op, b1.mem_we,
            b1.halted, b1.busy};
  endfunction

  function automatic logic [10:0] obs3();
    return {b3.pc_ld, b3.branch, b3.ir_ld, b3.adrs_sel,
            b3.acc_ld, b3.flags_ld, b3.alu_op, b3.mem_we,
            b3.halted, b3.busy};
  endfunction

  task automatic reset1();
    rst = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    b1.opcode = OP_LOAD;
    b1.zero = 1'b0;
    b1.carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t t[$];
    t.push_back(mk(H, H, L, OP_LOAD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_DEC));
    rst = 1'b1;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL reset[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_add_sub();
    step_t t[$];
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_DEC));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_LOAD));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_DEC));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_ADD));
    t.push_back(mk(L, H, L, OP_SUB, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_SUB, L, L, E_DEC));
    t.push_back(mk(L, L, L, OP_SUB, L, L, E_SUB));
    t.push_back(mk(L, L, L, OP_SUB, L, L, E_IDLE));
    reset1();
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL alu[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jumps();
    step_t t[$];
    t.push_back(mk(L, H, L, OP_JZ, H, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_JZ, H, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_JZ, H, L, E_DECB));
    t.push_back(mk(L, H, L, OP_JZ, L, H, E_FETCHL));
    t.push_back(mk(L, H, L, OP_JZ, L, H, E_DEC));
    t.push_back(mk(L, H, L, OP_JC, L, H, E_FETCHL));
    t.push_back(mk(L, H, L, OP_JC, L, H, E_DECB));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_DECB));
    t.push_back(mk(L, H, L, OP_JC, H, L, E_FETCHL));
    t.push_back(mk(L, L, L, OP_JC, H, L, E_DEC));
    t.push_back(mk(L, L, L, OP_JC, H, L, E_IDLE));
    reset1();
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL jump[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_step_store();
    step_t t[$];
    t.push_back(mk(L, L, H, OP_STORE, L, L, E_IDLE));
    t.push_back(mk(L, L, H, OP_STORE, L, L, E_FETCHL));
    t.push_back(mk(L, L, L, OP_STORE, L, L, E_DEC));
    t.push_back(mk(L, L, L, OP_STORE, L, L, E_STORE));
    t.push_back(mk(L, L, L, OP_STORE, L, L, E_IDLE));
    t.push_back(mk(L, L, L, OP_STORE, L, L, E_IDLE));
    reset1();
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL step[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    step_t t[$];
    t.push_back(mk(L, H, L, OP_HALT, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_HALT, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_HALT, L, L, E_DECH));
    t.push_back(mk(L, H, L, OP_HALT, L, L, E_HALT));
    t.push_back(mk(L, L, H, OP_HALT, L, L, E_HALT));
    t.push_back(mk(L, H, L, OP_LOAD, L, L, E_HALT));
    t.push_back(mk(H, H, L, OP_LOAD, L, L, E_HALT));
    t.push_back(mk(L, L, L, OP_LOAD, L, L, E_IDLE));
    t.push_back(mk(L, L, L, OP_LOAD, L, L, E_IDLE));
    reset1();
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL halt[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ml3();
    step_t t[$];
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCH));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCH));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_DEC));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_EXW));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_EXW));
    t.push_back(mk(L, L, L, OP_ADD, L, L, E_ADD));
    t.push_back(mk(L, L, L, OP_ADD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCH));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCH));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_DEC));
    t.push_back(mk(L, H, L, OP_ADD, L, L, E_EXW));
    t.push_back(mk(H, H, L, OP_ADD, L, L, E_EXW));
    t.push_back(mk(L, L, L, OP_ADD, L, L, E_IDLE));
    t.push_back(mk(L, L, L, OP_ADD, L, L, E_IDLE));
    rst3 = 1'b1;
    run3 = 1'b0;
    step3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    foreach (t[i]) begin
      rst3 = t[i].rst; run3 = t[i].run; step3 = t[i].stp;
      b3.opcode = t[i].op; b3.zero = t[i].z; b3.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs3() !== t[i].exp) begin
        fails++;
        $display("FAIL lat3[%0d] got %b want %b",
                 i, obs3(), t[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef CPU_SEQ_BREAKPOINT_EN
  task automatic test_bp();
    step_t t[$];
    bit    hit[$];
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_FETCHL));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_DECB));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_IDLE));
    t.push_back(mk(L, L, L, OP_JMP, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_IDLE));
    t.push_back(mk(L, H, L, OP_JMP, L, L, E_FETCHL));
    hit = '{L, L, L, H, L, L, L, L};
    bp_en = 1'b1;
    bp_adrs = 5'd7;
    pc_val = 5'd7;
    reset1();
    foreach (t[i]) begin
      rst = t[i].rst; run = t[i].run; step_req = t[i].stp;
      b1.opcode = t[i].op; b1.zero = t[i].z; b1.carry = t[i].c;
      @(negedge clk);
      asserts++;
      if (obs1() !== t[i].exp) begin
        fails++;
        $display("FAIL bp[%0d] got %b want %b",
                 i, obs1(), t[i].exp);
      end
      asserts++;
      if (bp_hit !== hit[i]) begin
        fails++;
        $display("FAIL bp_hit[%0d] got %b want %b",
                 i, bp_hit, hit[i]);
      end
      @(posedge clk);
      #1;
    end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    rst3 = 1'b1;
    run3 = 1'b0;
    step3 = 1'b0;
    b1.opcode = OP_LOAD;
    b1.zero = 1'b0;
    b1.carry = 1'b0;
    b3.opcode = OP_LOAD;
    b3.zero = 1'b0;
    b3.carry = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
    bp_en = 1'b0;
    bp_adrs = '0;
    pc_val = '0;
`endif
    test_reset();
    test_load_add_sub();
    test_jumps();
    test_step_store();
    test_halt();
    test_ml3();
`ifdef CPU_SEQ_BREAKPOINT_EN
    test_bp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Instruction-sequencing FSM for the 5-bit-address accumulator CPU.
- Drives PC load/branch select, IR load, memory address select, accumulator/flag loads, ALU op and memory write.
- Gates execution by run/single-step mode.
- Sits between the instruction register / flag registers and the PC/address-generation datapath.

Parameters:
- ADRS_W, 5, memory address width (instruction operand field).
- OP_W, 3, opcode field width; instruction width = OP_W+ADRS_W.
- MEM_LAT, 1, memory read latency in cycles (1..4); the address must be held for this many cycles before data is captured.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = free-run; 0 = single-step
- step_req  in  1  single-cycle pulse, already debounced/synchronized; advances one instruction in step mode
- opcode  in  OP_W  IR[7:5], valid from DECODE onward
- zero  in  1  registered zero flag from datapath
- carry  in  1  registered carry flag from datapath
- pc_ld  out  1  one-cycle PC load strobe
- branch  out  1  PC mux select: 1 = IR operand, 0 = PC+1; valid while pc_ld=1
- ir_ld  out  1  instruction register load strobe
- adrs_sel  out  1  memory address mux: 0 = PC, 1 = IR operand
- acc_ld  out  1  accumulator load strobe
- flags_ld  out  1  zero/carry register load strobe
- alu_op  out  2  00 pass (LOAD), 01 ADD, 10 SUB, 11 reserved
- mem_we  out  1  memory write strobe (STORE)
- halted  out  1  level, HALT executed
- busy  out  1  level, instruction in progress (state not IDLE/HALTED)

Behaviour:
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 JMP, 101 JZ, 110 JC, 111 HALT.
- States: IDLE, FETCH, DECODE, EXEC, HALTED. A wait counter of width clog2(MEM_LAT+1) is shared by FETCH and EXEC.
- Reset (sync, any state, mid-instruction included): state=IDLE, counter=0, all strobes 0, alu_op=00, adrs_sel=0, halted=0, busy=0.
- IDLE: leaves to FETCH when run=1 or step_req=1; otherwise stays.
- FETCH: adrs_sel=0. Counts MEM_LAT cycles. ir_ld=1 on the final cycle, then goes to DECODE.
- DECODE: one cycle, pc_ld=1 always except on HALT.
  - branch = JMP | (JZ&zero) | (JC&carry), using flag values sampled in this cycle.
  - Jumps and not-taken conditional jumps end the instruction here.
  - LOAD/ADD/SUB/STORE go to EXEC.
  - HALT: pc_ld=0, go to HALTED.
- EXEC, LOAD/ADD/SUB: adrs_sel=1, counts MEM_LAT cycles. On the final cycle acc_ld=1, flags_ld=1, alu_op per opcode.
- EXEC, STORE: adrs_sel=1, mem_we=1 for exactly one cycle, no wait; flags unchanged.
- End of instruction: next state is FETCH if run=1, else IDLE. A step_req arriving mid-instruction is ignored (not queued).
- HALTED: all strobes 0, halted=1; exits only via rst.
- Strobes are Moore outputs decoded from state+counter, glitch-free and registered-state based.
- At most one of pc_ld/ir_ld/acc_ld/mem_we is high in any cycle.
- Per-instruction cycles:
  - Jumps: MEM_LAT+1.
  - LOAD/ADD/SUB: 2*MEM_LAT+1.
  - STORE: MEM_LAT+2.
- The PC wraps 31→0 in the datapath; the controller has no special case for it.

Optional Feature:
- Macro: CPU_SEQ_BREAKPOINT_EN.
- When defined, adds ports bp_en (in, 1), bp_adrs (in, ADRS_W), pc_val (in, ADRS_W) and bp_hit (out, 1).
- Breakpoint check: at the end of an instruction, if bp_en=1 and pc_val==bp_adrs, go to IDLE regardless of run and pulse bp_hit for one cycle.
- Resuming from the breakpoint requires step_req, or run toggling 0→1 after bp_hit.
- When the macro is undefined, none of these ports exist and behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_LOAD..OP_HALT);
  - alu_op encodings (ALU_PASS, ALU_ADD, ALU_SUB);
  - FSM state enum;
  - the ADRS_W/OP_W defaults.
- The decode/branch-condition logic is one natural sub-module, cpu_branch_dec: opcode, zero, carry in; branch, is_mem_op, is_store, is_halt out. It is combinational and instantiated once.

Test Plan:
- rst held 3 cycles with run=1 → IDLE, all outputs 0. After release: FETCH, ir_ld at cycle MEM_LAT, pc_ld on the next cycle.
- run=1, MEM_LAT=1, program LOAD 5; ADD 6 → acc_ld+flags_ld with alu_op 00 then 01; 3 cycles per instruction; adrs_sel=1 only in EXEC.
- JZ with zero=1 → pc_ld=1, branch=1. JZ with zero=0 → pc_ld=1, branch=0. JC with carry=1 → branch=1. Each takes 2 cycles with no EXEC.
- run=0, step_req pulse → exactly one STORE executed (mem_we high for 1 cycle), then IDLE. A second step_req pulse during FETCH is ignored.
- HALT opcode → halted=1, no pc_ld. run/step_req toggling has no effect. rst returns to IDLE.
- rst asserted during EXEC of ADD (MEM_LAT=3) → next cycle IDLE with no acc_ld. With CPU_SEQ_BREAKPOINT_EN and bp_adrs=pc_val=7 → bp_hit pulse, IDLE despite run=1.
